tt_um_c8_restoring_div: RTL

TT_UM_C8_RESTORING_DIV -- requirements
Module: tt_um_c8_restoring_div

---
 rtl/c8_div_pkg.sv | 19 +
 rtl/c8_div_step.sv | 30 +++
 rtl/tt_um_c8_restoring_div.sv | 125 ++++++++++++
 3 files changed

// File: rtl/c8_div_pkg.sv
// Shared definitions for the c8 restoring divider: widths, FSM states, uio bit map.
package c8_div_pkg;

    localparam int DIVIDEND_W_DEFAULT = 8;
    localparam int DIVISOR_W_DEFAULT  = 4;

    // uio_in / uio_out bit positions
    localparam int START_BIT   = 4;
    localparam int OUT_SEL_BIT = 5;
    localparam int BUSY_BIT    = 6;
    localparam int DONE_BIT    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/c8_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module c8_div_step
    import c8_div_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEFAULT
) (
    input  logic [DIVISOR_W-1:0] prem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] trial;
    logic [DIVISOR_W:0] diff;

    // Trial subtraction; the result always fits DIVISOR_W bits because prem < divisor.
    always_comb begin
        trial    = {prem, next_bit};
        diff     = trial - {1'b0, divisor};
        q_bit    = 1'b0;
        rem_next = trial[DIVISOR_W-1:0];
        if (trial >= {1'b0, divisor}) begin
            q_bit    = 1'b1;
            rem_next = diff[DIVISOR_W-1:0];
        end
    end

endmodule

// File: rtl/tt_um_c8_restoring_div.sv
// Unsigned sequential restoring divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock, divide-by-zero flagged with a saturated quotient.
module tt_um_c8_restoring_div
    import c8_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEFAULT,
    parameter int DIVISOR_W  = DIVISOR_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int             CNT_W    = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [DIVIDEND_W-1:0]  shift_q;    // dividend bits shift out the top, quotient bits enter the bottom
    logic [DIVISOR_W-1:0]   divisor_r;
    logic [DIVISOR_W-1:0]   prem;
    logic [DIVIDEND_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]   remainder;
    logic                   dbz;
    logic                   busy;
    logic                   done;

    logic                   start;
    logic                   out_sel;
    logic                   accept;
    logic [DIVISOR_W-1:0]   rem_next;
    logic                   q_bit;
    logic                   unused_ok;

    assign start     = uio_in[START_BIT];
    assign out_sel   = uio_in[OUT_SEL_BIT];
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign unused_ok = &{1'b0, ena, uio_in[7:6]};

    c8_div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .prem     (prem),
        .next_bit (shift_q[DIVIDEND_W-1]),
        .divisor  (divisor_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Control FSM plus datapath registers; busy/done are registered state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_q   <= '0;
            divisor_r <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        shift_q   <= ui_in[DIVIDEND_W-1:0];
                        divisor_r <= uio_in[DIVISOR_W-1:0];
                        prem      <= '0;
                        cnt       <= '0;
                        dbz       <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (divisor_r == '0) begin
                        // Dividend is still unshifted here, so its low bits are the remainder view.
                        quotient  <= '1;
                        remainder <= shift_q[DIVISOR_W-1:0];
                        dbz       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        prem    <= rem_next;
                        shift_q <= {shift_q[DIVIDEND_W-2:0], q_bit};
                        if (cnt == LAST_CNT) begin
                            quotient  <= {shift_q[DIVIDEND_W-2:0], q_bit};
                            remainder <= rem_next;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Output view select: quotient, or {dbz, zeros, remainder}.
    always_comb begin
        uo_out = quotient;
        if (out_sel) begin
            uo_out = {dbz, {(7 - DIVISOR_W){1'b0}}, remainder};
        end
    end

    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule
